jelly2_img_frame_sequencer: RTL and testbench

JELLY2_IMG_FRAME_SEQUENCER -- requirements
Module: jelly2_img_frame_sequencer

---
 rtl/jelly2_img_frame_sequencer_if.sv | 26 ++
 rtl/jelly2_img_frame_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_jelly2_img_frame_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly2_img_frame_sequencer_if.sv
// Image stream bundle carried from the frame sequencer to the block buffer.
interface jelly2_img_frame_sequencer_if #(
  parameter int X_WIDTH = 16,
  parameter int Y_WIDTH = 16,
  parameter int F_WIDTH = 32
);

  logic               row_first;
  logic               row_last;
  logic               col_first;
  logic               col_last;
  logic               de;
  logic               valid;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic [F_WIDTH-1:0] f;

  modport master (
    output row_first, row_last, col_first, col_last, de, valid, x, y, f
  );

  modport slave (
    input  row_first, row_last, col_first, col_last, de, valid, x, y, f
  );

endinterface

// File: rtl/jelly2_img_frame_sequencer.sv
// Frame sequencer: walks x/y over a width x height frame with optional
// horizontal blanking and trailing de=0 flush lines, emitting fully
// registered image-stream control signals.
module jelly2_img_frame_sequencer #(
  parameter int X_WIDTH      = 16,
  parameter int Y_WIDTH      = 16,
  parameter int F_WIDTH      = 32,
  parameter int HBLANK_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,

  input  logic                    enable,
  output logic                    busy,

  input  logic [X_WIDTH-1:0]      param_width,
  input  logic [Y_WIDTH-1:0]      param_height,
  input  logic [HBLANK_WIDTH-1:0] param_x_blank,
  input  logic [Y_WIDTH-1:0]      param_y_flush,

  jelly2_img_frame_sequencer_if.master m_img,

  output logic                    frame_start,
  output logic                    frame_end
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LINE   = 2'd1,
    ST_HBLANK = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // state and counters
  state_t                  state_q,     state_d;
  logic [X_WIDTH-1:0]      x_q,         x_d;
  logic [Y_WIDTH-1:0]      y_q,         y_d;
  logic [F_WIDTH-1:0]      f_q,         f_d;
  logic [HBLANK_WIDTH-1:0] blank_cnt_q, blank_cnt_d;

  // parameters latched at each frame start
  logic [X_WIDTH-1:0]      width_q,     width_d;
  logic [Y_WIDTH-1:0]      height_q,    height_d;
  logic [HBLANK_WIDTH-1:0] x_blank_q,   x_blank_d;
  logic [Y_WIDTH-1:0]      y_flush_q,   y_flush_d;

  // registered outputs
  logic valid_q,       valid_d;
  logic de_q,          de_d;
  logic row_first_q,   row_first_d;
  logic row_last_q,    row_last_d;
  logic col_first_q,   col_first_d;
  logic col_last_q,    col_last_d;
  logic frame_start_q, frame_start_d;
  logic frame_end_q,   frame_end_d;
  logic busy_q,        busy_d;

  // decode helpers
  logic               line_adv;
  logic               start;
  logic               in_flush;
  logic               last_row;
  logic               last_flush;
  logic [Y_WIDTH-1:0] flush_idx;
  logic [X_WIDTH-1:0] width_m1;
  logic [Y_WIDTH-1:0] height_m1;
  logic [X_WIDTH-1:0] width_m1_d;
  logic [Y_WIDTH-1:0] height_m1_d;
  logic [Y_WIDTH-1:0] flush_idx_d;
  logic               last_line_d;

  // Next-state, next-counter and next-output computation for one cke beat.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    blank_cnt_d = blank_cnt_q;
    width_d     = width_q;
    height_d    = height_q;
    x_blank_d   = x_blank_q;
    y_flush_d   = y_flush_q;
    f_d         = frame_end_q ? (f_q + F_WIDTH'(1)) : f_q;

    line_adv    = 1'b0;
    start       = 1'b0;

    width_m1    = width_q - X_WIDTH'(1);
    height_m1   = height_q - Y_WIDTH'(1);
    in_flush    = (y_q >= height_q);
    last_row    = (y_q == height_m1);
    flush_idx   = y_q - height_q;
    last_flush  = in_flush && (flush_idx == (y_flush_q - Y_WIDTH'(1)));

    case (state_q)
      ST_IDLE: begin
        x_d   = '0;
        y_d   = '0;
        start = enable;
      end
      ST_LINE, ST_FLUSH: begin
        if (x_q == width_m1) begin
          if (x_blank_q != '0) begin
            state_d     = ST_HBLANK;
            blank_cnt_d = x_blank_q - HBLANK_WIDTH'(1);
          end else begin
            line_adv = 1'b1;
          end
        end else begin
          x_d = x_q + X_WIDTH'(1);
        end
      end
      ST_HBLANK: begin
        if (blank_cnt_q == '0) begin
          line_adv = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q - HBLANK_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End of a line (plus its blanking): next row, flush, or frame done.
    if (line_adv) begin
      x_d = '0;
      if (!in_flush && !last_row) begin
        state_d = ST_LINE;
        y_d     = y_q + Y_WIDTH'(1);
      end else if (!in_flush && (y_flush_q != '0)) begin
        state_d = ST_FLUSH;
        y_d     = y_q + Y_WIDTH'(1);
      end else if (in_flush && !last_flush) begin
        state_d = ST_FLUSH;
        y_d     = y_q + Y_WIDTH'(1);
      end else begin
        state_d = ST_IDLE;
        y_d     = '0;
        start   = enable;
      end
    end

    // A new frame latches fresh parameters; zero sizes become 1.
    if (start) begin
      state_d   = ST_LINE;
      x_d       = '0;
      y_d       = '0;
      width_d   = (param_width  == '0) ? X_WIDTH'(1) : param_width;
      height_d  = (param_height == '0) ? Y_WIDTH'(1) : param_height;
      x_blank_d = param_x_blank;
      y_flush_d = param_y_flush;
    end

    width_m1_d    = width_d - X_WIDTH'(1);
    height_m1_d   = height_d - Y_WIDTH'(1);
    flush_idx_d   = y_d - height_d;

    valid_d       = (state_d == ST_LINE) || (state_d == ST_FLUSH);
    de_d          = (state_d == ST_LINE);
    col_first_d   = valid_d && (x_d == '0);
    col_last_d    = valid_d && (x_d == width_m1_d);
    row_first_d   = de_d && (y_d == '0);
    row_last_d    = de_d && (y_d == height_m1_d);
    frame_start_d = valid_d && row_first_d && col_first_d;
    last_line_d   = (row_last_d && (y_flush_d == '0)) ||
                    ((state_d == ST_FLUSH) && (flush_idx_d == (y_flush_d - Y_WIDTH'(1))));
    frame_end_d   = col_last_d && last_line_d;
    busy_d        = (state_d != ST_IDLE);
  end

  // All state and outputs: async reset, update only on cke beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      f_q           <= '0;
      blank_cnt_q   <= '0;
      width_q       <= X_WIDTH'(1);
      height_q      <= Y_WIDTH'(1);
      x_blank_q     <= '0;
      y_flush_q     <= '0;
      valid_q       <= 1'b0;
      de_q          <= 1'b0;
      row_first_q   <= 1'b0;
      row_last_q    <= 1'b0;
      col_first_q   <= 1'b0;
      col_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else if (cke) begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      f_q           <= f_d;
      blank_cnt_q   <= blank_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;
      x_blank_q     <= x_blank_d;
      y_flush_q     <= y_flush_d;
      valid_q       <= valid_d;
      de_q          <= de_d;
      row_first_q   <= row_first_d;
      row_last_q    <= row_last_d;
      col_first_q   <= col_first_d;
      col_last_q    <= col_last_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
    end
  end

  assign m_img.row_first = row_first_q;
  assign m_img.row_last  = row_last_q;
  assign m_img.col_first = col_first_q;
  assign m_img.col_last  = col_last_q;
  assign m_img.de        = de_q;
  assign m_img.valid     = valid_q;
  assign m_img.x         = x_q;
  assign m_img.y         = y_q;
  assign m_img.f         = f_q;

  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_jelly2_img_frame_sequencer.sv
// Scoreboard bench for the frame sequencer: a frame model pushes the
// expected per-beat output stream, a negedge monitor pops and compares.
module tb_jelly2_img_frame_sequencer;

  localparam int XW = 16;
  localparam int YW = 16;
  localparam int FW = 32;
  localparam int HW = 8;

  logic          clk;
  logic          reset_n;
  logic          cke;
  logic          enable;
  logic          busy;
  logic [XW-1:0] param_width;
  logic [YW-1:0] param_height;
  logic [HW-1:0] param_x_blank;
  logic [YW-1:0] param_y_flush;
  logic          frame_start;
  logic          frame_end;

  jelly2_img_frame_sequencer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .F_WIDTH(FW)) m_img ();

  jelly2_img_frame_sequencer #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .F_WIDTH(FW), .HBLANK_WIDTH(HW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cke           (cke),
    .enable        (enable),
    .busy          (busy),
    .param_width   (param_width),
    .param_height  (param_height),
    .param_x_blank (param_x_blank),
    .param_y_flush (param_y_flush),
    .m_img         (m_img),
    .frame_start   (frame_start),
    .frame_end     (frame_end)
  );

  // flags = {valid, de, row_first, row_last, col_first, col_last, frame_start, frame_end}
  typedef struct packed {
    logic [7:0]    flags;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] f;
  } beat_t;

  beat_t         sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            tracking = 0;
  logic [FW-1:0] exp_f = '0;

  logic          cke_at_edge = 1'b1;
  logic          rst_at_edge = 1'b0;
  logic [7:0]    last_flags = '0;
  logic [XW-1:0] last_x = '0;
  logic [YW-1:0] last_y = '0;
  logic [FW-1:0] last_f = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int w, input int h, input int xb, input int yf);
    param_width   = XW'(w);
    param_height  = YW'(h);
    param_x_blank = HW'(xb);
    param_y_flush = YW'(yf);
  endtask

  // Expected beats of one frame, from its first pixel to its frame_end beat.
  task automatic pushFrame(input int w, input int h, input int xb, input int yf, input logic [FW-1:0] fnum);
    int    wc;
    int    hc;
    int    total;
    beat_t b;
    logic  de, rf, rl, cf, cl;
    wc    = (w == 0) ? 1 : w;
    hc    = (h == 0) ? 1 : h;
    total = hc + yf;
    for (int ly = 0; ly < total; ly++) begin
      for (int lx = 0; lx < wc; lx++) begin
        de = (ly < hc);
        rf = de && (ly == 0);
        rl = de && (ly == hc - 1);
        cf = (lx == 0);
        cl = (lx == wc - 1);
        b.flags = {1'b1, de, rf, rl, cf, cl, rf && cf, (ly == total - 1) && cl};
        b.x     = XW'(lx);
        b.y     = YW'(ly);
        b.f     = fnum;
        sb.push_back(b);
      end
      if (ly != total - 1) begin
        for (int k = 0; k < xb; k++) begin
          b.flags = '0;
          b.x     = '0;
          b.y     = '0;
          b.f     = fnum;
          sb.push_back(b);
        end
      end
    end
  endtask

  function automatic logic [7:0] obsFlags();
    return {m_img.valid, m_img.de, m_img.row_first, m_img.row_last,
            m_img.col_first, m_img.col_last, frame_start, frame_end};
  endfunction

  // Remember whether the edge just taken was an active beat.
  always @(posedge clk) begin
    cke_at_edge = cke;
    rst_at_edge = reset_n;
  end

  // Monitor: compare each active beat against the scoreboard, and check
  // that outputs hold still across cke=0 edges.
  always @(negedge clk) begin
    beat_t      e;
    logic [7:0] cur;
    cur = obsFlags();
    if (reset_n && rst_at_edge) begin
      if (!cke_at_edge) begin
        checkOutput("frozen flags", 64'(cur), 64'(last_flags));
        checkOutput("frozen x", 64'(m_img.x), 64'(last_x));
        checkOutput("frozen y", 64'(m_img.y), 64'(last_y));
        checkOutput("frozen f", 64'(m_img.f), 64'(last_f));
      end else begin
        if (!tracking && (sb.size() > 0) && frame_start) tracking = 1;
        if (tracking) begin
          e = sb.pop_front();
          checkOutput("flags", 64'(cur), 64'(e.flags));
          if (e.flags[7]) begin
            checkOutput("x", 64'(m_img.x), 64'(e.x));
            checkOutput("y", 64'(m_img.y), 64'(e.y));
          end
          checkOutput("f", 64'(m_img.f), 64'(e.f));
          if (sb.size() == 0) tracking = 0;
        end
      end
    end
    last_flags = cur;
    last_x     = m_img.x;
    last_y     = m_img.y;
    last_f     = m_img.f;
  end

  task automatic waitDrained(input string tag);
    for (int i = 0; i < 2000 && !((sb.size() == 0) && !busy); i++) @(negedge clk);
    checkOutput({tag, " drained"}, 64'((sb.size() == 0) && !busy), 64'd1);
  endtask

  task automatic pulseEnable();
    enable = 1'b1;
    for (int i = 0; i < 100 && !busy; i++) @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " flags"}, 64'(obsFlags()), 64'd0);
    checkOutput({tag, " x"}, 64'(m_img.x), 64'd0);
    checkOutput({tag, " y"}, 64'(m_img.y), 64'd0);
    checkOutput({tag, " f"}, 64'(m_img.f), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    cke     = 1'b1;
    enable  = 1'b0;
    applyStimulus(4, 3, 0, 0);
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] 4x3 back-to-back frames");
    pushFrame(4, 3, 0, 0, exp_f);
    pushFrame(4, 3, 0, 0, exp_f + 1);
    exp_f = exp_f + 2;
    enable = 1'b1;
    for (int i = 0; i < 200 && sb.size() > 6; i++) @(negedge clk);
    enable = 1'b0;
    waitDrained("back-to-back");

    $display("[TB] 4x2 with hblank and flush");
    applyStimulus(4, 2, 2, 2);
    pushFrame(4, 2, 2, 2, exp_f);
    exp_f++;
    pulseEnable();
    waitDrained("blank+flush");

    $display("[TB] 4x3 with cke toggling");
    applyStimulus(4, 3, 0, 0);
    pushFrame(4, 3, 0, 0, exp_f);
    exp_f++;
    enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cke = ~cke;
      if (busy) enable = 1'b0;
      if ((sb.size() == 0) && !busy) break;
    end
    @(negedge clk);
    cke = 1'b1;
    enable = 1'b0;
    waitDrained("cke toggle");

    $display("[TB] enable dropped mid-frame");
    pushFrame(4, 3, 0, 0, exp_f);
    exp_f++;
    enable = 1'b1;
    for (int i = 0; i < 200 && !(m_img.valid && m_img.x == 1 && m_img.y == 1); i++) @(negedge clk);
    enable = 1'b0;
    waitDrained("enable drop");
    repeat (5) @(negedge clk);
    checkOutput("stays idle busy", 64'(busy), 64'd0);
    checkOutput("stays idle valid", 64'(m_img.valid), 64'd0);

    $display("[TB] reset mid-frame");
    pushFrame(4, 3, 0, 0, exp_f);
    enable = 1'b1;
    for (int i = 0; i < 200 && !(m_img.valid && m_img.x == 2 && m_img.y == 1); i++) @(negedge clk);
    checkOutput("reached (2,1)", 64'(m_img.valid && m_img.x == 2 && m_img.y == 1), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("async reset");
    sb.delete();
    tracking = 0;
    exp_f = '0;
    pushFrame(4, 3, 0, 0, exp_f);
    exp_f++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100 && !busy; i++) @(negedge clk);
    enable = 1'b0;
    waitDrained("after reset");

    $display("[TB] zero width and height");
    applyStimulus(0, 0, 0, 0);
    pushFrame(0, 0, 0, 0, exp_f);
    exp_f++;
    pulseEnable();
    waitDrained("1x1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
